// File: rtl/mmss_countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the m:ss countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BLANK_CODE      = 4'hF;
    localparam bcd_t DIGIT_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_RELOAD = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_RUNNING = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Blank or non-decimal key codes enter the counter as 0.
    function automatic bcd_t sanitize_digit(input bcd_t d, input bcd_t blank);
        return ((d == blank) || (d > DIGIT_MAX)) ? 4'd0 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmss_countdown_timer_bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One loadable BCD down-counting digit with borrow output.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit (
    input  logic       clk,
    input  logic       clrn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic [3:0] wrap_val,
    output logic [3:0] q,
    output logic       borrow_out
);
    import timer_pkg::*;

    bcd_t w_dec_val;

    assign w_dec_val  = (q == 4'd0) ? wrap_val : (q - 4'd1);
    assign borrow_out = dec & (q == 4'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= w_dec_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmss_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmss_countdown_timer
// Description : Loadable m:ss BCD countdown driven by a resynchronised 1 Hz tick.
// Revision    : 1.0 - initial release
// ============================================================================
module mmss_countdown_timer #(
    parameter int         SYNC_STAGES     = 2,
    parameter logic [3:0] BLANK_CODE      = 4'hF,
    parameter int         SEC_TENS_RELOAD = 5
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       enablen,
    input  logic       pgt_1Hz,
    input  logic [3:0] in_sec_ones,
    input  logic [3:0] in_sec_tens,
    input  logic [3:0] in_min_ones,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       zero,
    output logic       running,
    output logic       expired
);
    import timer_pkg::*;

    localparam bcd_t C_TENS_WRAP = 4'(SEC_TENS_RELOAD);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_tick;
    state_e                 r_state;
    state_e                 w_next_state;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_one;
    logic                   w_bo_ones;
    logic                   w_bo_tens;
    logic                   w_bo_min;

    // pgt_1Hz is asynchronous; only the last stage feeds the edge detector.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pgt_1Hz};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

    assign w_load = ~loadn;
    assign w_dec  = loadn & ~enablen & w_tick & (r_state == ST_RUNNING);
    assign zero   = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign w_one  = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    bcd_down_digit u_sec_ones (
        .clk        (clk),
        .clrn       (clrn),
        .load       (w_load),
        .load_val   (sanitize_digit(in_sec_ones, BLANK_CODE)),
        .dec        (w_dec),
        .wrap_val   (DIGIT_MAX),
        .q          (sec_ones),
        .borrow_out (w_bo_ones)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .clrn       (clrn),
        .load       (w_load),
        .load_val   (sanitize_digit(in_sec_tens, BLANK_CODE)),
        .dec        (w_bo_ones),
        .wrap_val   (C_TENS_WRAP),
        .q          (sec_tens),
        .borrow_out (w_bo_tens)
    );

    bcd_down_digit u_min_ones (
        .clk        (clk),
        .clrn       (clrn),
        .load       (w_load),
        .load_val   (sanitize_digit(in_min_ones, BLANK_CODE)),
        .dec        (w_bo_tens),
        .wrap_val   (DIGIT_MAX),
        .q          (min_ones),
        .borrow_out (w_bo_min)
    );

    always_comb begin
        w_next_state = r_state;
        if (!loadn) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:    w_next_state = zero ? ST_IDLE : ST_PAUSED;
                ST_PAUSED:  if (!enablen) w_next_state = ST_RUNNING;
                ST_RUNNING: begin
                    if (enablen) begin
                        w_next_state = ST_PAUSED;
                    end else if (w_dec && (w_one || w_bo_min)) begin
                        // a minutes borrow cannot occur; treat it as expiry anyway
                        w_next_state = ST_DONE;
                    end
                end
                default:    w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            r_state <= w_next_state;
            running <= (w_next_state == ST_RUNNING);
            expired <= w_dec & w_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmss_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmss_countdown_timer
// Description : Directed self-checking bench for the m:ss countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmss_countdown_timer;
    import timer_pkg::*;

    logic       clk = 1'b0;
    logic       clrn;
    logic       loadn;
    logic       enablen;
    logic       pgt_1Hz;
    logic [3:0] in_sec_ones;
    logic [3:0] in_sec_tens;
    logic [3:0] in_min_ones;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       zero;
    logic       running;
    logic       expired;
    logic [11:0] digits;

    int total = 0;
    int bad   = 0;

    mmss_countdown_timer #(
        .SYNC_STAGES     (2),
        .BLANK_CODE      (4'hF),
        .SEC_TENS_RELOAD (5)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .loadn       (loadn),
        .enablen     (enablen),
        .pgt_1Hz     (pgt_1Hz),
        .in_sec_ones (in_sec_ones),
        .in_sec_tens (in_sec_tens),
        .in_min_ones (in_min_ones),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .zero        (zero),
        .running     (running),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    assign digits = {min_ones, sec_tens, sec_ones};

    function automatic logic [11:0] bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic pulse();
        pgt_1Hz = 1'b1;
        repeat (3) @(negedge clk);
        pgt_1Hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        in_min_ones = m;
        in_sec_tens = t;
        in_sec_ones = o;
        loadn = 1'b0;
        repeat (2) @(negedge clk);
        loadn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (digits !== 12'h000) begin $display("FAIL reset_digits got %h want 000", digits); bad++; end
        total++; if (zero !== 1'b1) begin $display("FAIL reset_zero got %b want 1", zero); bad++; end
        total++; if (running !== 1'b0 || expired !== 1'b0) begin
            $display("FAIL reset_flags got run=%b exp=%b want 0 0", running, expired); bad++; end
        total++; if (dut.r_state !== ST_IDLE) begin $display("FAIL reset_state got %0d want IDLE", dut.r_state); bad++; end
    endtask

    task automatic test_load();
        load(4'd1, 4'd3, 4'd0);
        total++; if (digits !== 12'h130) begin $display("FAIL load_130 got %h want 130", digits); bad++; end
        total++; if (zero !== 1'b0) begin $display("FAIL load_zero got %b want 0", zero); bad++; end
        total++; if (dut.r_state !== ST_PAUSED) begin $display("FAIL load_state got %0d want PAUSED", dut.r_state); bad++; end
        pulse();
        pulse();
        total++; if (digits !== 12'h130 || running !== 1'b0) begin
            $display("FAIL paused_hold got %h run=%b want 130 run=0", digits, running); bad++; end
    endtask

    task automatic test_count();
        enablen = 1'b0;
        @(negedge clk);
        total++; if (running !== 1'b1) begin $display("FAIL run_start got %b want 1", running); bad++; end
        for (int i = 0; i < 3; i++) begin
            pgt_1Hz = 1'b1;
            repeat (2) @(negedge clk);
            total++; if (digits !== bcd(90 - i)) begin
                $display("FAIL latency_early got %h want %h", digits, bcd(90 - i)); bad++; end
            @(negedge clk);
            total++; if (digits !== bcd(89 - i)) begin
                $display("FAIL latency_update got %h want %h", digits, bcd(89 - i)); bad++; end
            pgt_1Hz = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (28) pulse();
        total++; if (digits !== 12'h059) begin $display("FAIL count_059 got %h want 059", digits); bad++; end
        total++; if (expired !== 1'b0 || running !== 1'b1) begin
            $display("FAIL count_flags got exp=%b run=%b want 0 1", expired, running); bad++; end
    endtask

    task automatic test_expire();
        enablen = 1'b1;
        load(4'd0, 4'd0, 4'd2);
        total++; if (digits !== 12'h002 || dut.r_state !== ST_PAUSED) begin
            $display("FAIL load_002 got %h st=%0d want 002 PAUSED", digits, dut.r_state); bad++; end
        enablen = 1'b0;
        @(negedge clk);
        pulse();
        total++; if (digits !== 12'h001) begin $display("FAIL count_001 got %h want 001", digits); bad++; end
        pgt_1Hz = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (digits !== 12'h000 || zero !== 1'b1) begin
            $display("FAIL expire_digits got %h z=%b want 000 z=1", digits, zero); bad++; end
        total++; if (expired !== 1'b1) begin $display("FAIL expire_pulse got %b want 1", expired); bad++; end
        total++; if (dut.r_state !== ST_DONE || running !== 1'b0) begin
            $display("FAIL expire_state got st=%0d run=%b want DONE 0", dut.r_state, running); bad++; end
        @(negedge clk);
        total++; if (expired !== 1'b0) begin $display("FAIL expire_width got %b want 0", expired); bad++; end
        pgt_1Hz = 1'b0;
        repeat (2) @(negedge clk);
        pulse();
        pulse();
        total++; if (digits !== 12'h000 || dut.r_state !== ST_DONE || expired !== 1'b0) begin
            $display("FAIL done_hold got %h st=%0d exp=%b want 000 DONE 0", digits, dut.r_state, expired); bad++; end
    endtask

    task automatic test_sanitise();
        enablen = 1'b1;
        load(4'hF, 4'hF, 4'd5);
        total++; if (digits !== 12'h005) begin $display("FAIL blank_load got %h want 005", digits); bad++; end
        load(4'd3, 4'd4, 4'hA);
        total++; if (digits !== 12'h340) begin $display("FAIL nondec_load got %h want 340", digits); bad++; end
        load(4'd0, 4'd9, 4'd0);
        total++; if (digits !== 12'h090 || dut.r_state !== ST_PAUSED) begin
            $display("FAIL tens9_load got %h st=%0d want 090 PAUSED", digits, dut.r_state); bad++; end
        load(4'd0, 4'd0, 4'd0);
        total++; if (dut.r_state !== ST_IDLE || zero !== 1'b1) begin
            $display("FAIL zero_load got st=%0d z=%b want IDLE 1", dut.r_state, zero); bad++; end
        enablen = 1'b0;
        repeat (2) @(negedge clk);
        pulse();
        total++; if (running !== 1'b0 || dut.r_state !== ST_IDLE || digits !== 12'h000) begin
            $display("FAIL idle_ignore got run=%b st=%0d %h want 0 IDLE 000", running, dut.r_state, digits); bad++; end
    endtask

    task automatic test_drop();
        enablen = 1'b1;
        load(4'd0, 4'd1, 4'd0);
        enablen = 1'b0;
        @(negedge clk);
        total++; if (running !== 1'b1) begin $display("FAIL drop_run got %b want 1", running); bad++; end
        pgt_1Hz = 1'b1;
        repeat (2) @(negedge clk);
        enablen = 1'b1;
        @(negedge clk);
        total++; if (digits !== 12'h010 || running !== 1'b0) begin
            $display("FAIL drop_tick got %h run=%b want 010 0", digits, running); bad++; end
        pgt_1Hz = 1'b0;
        repeat (2) @(negedge clk);
        enablen = 1'b0;
        @(negedge clk);
        pulse();
        total++; if (digits !== 12'h009 || running !== 1'b1) begin
            $display("FAIL resume_009 got %h run=%b want 009 1", digits, running); bad++; end
    endtask

    task automatic test_abort();
        enablen = 1'b1;
        load(4'd2, 4'd0, 4'd0);
        enablen = 1'b0;
        @(negedge clk);
        pgt_1Hz = 1'b1;
        repeat (2) @(negedge clk);
        in_min_ones = 4'd0;
        in_sec_tens = 4'd4;
        in_sec_ones = 4'd5;
        loadn = 1'b0;
        @(negedge clk);
        total++; if (digits !== 12'h045 || expired !== 1'b0 || dut.r_state !== ST_LOAD) begin
            $display("FAIL abort_load got %h exp=%b st=%0d want 045 0 LOAD", digits, expired, dut.r_state); bad++; end
        loadn = 1'b1;
        pgt_1Hz = 1'b0;
        @(negedge clk);
        total++; if (dut.r_state !== ST_PAUSED || expired !== 1'b0) begin
            $display("FAIL abort_paused got st=%0d exp=%b want PAUSED 0", dut.r_state, expired); bad++; end
        @(negedge clk);
        pulse();
        total++; if (digits !== 12'h044 || running !== 1'b1) begin
            $display("FAIL abort_count got %h run=%b want 044 1", digits, running); bad++; end
        pgt_1Hz = 1'b1;
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        total++; if (digits !== 12'h000 || zero !== 1'b1 || running !== 1'b0) begin
            $display("FAIL async_reset got %h z=%b run=%b want 000 1 0", digits, zero, running); bad++; end
        @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        pgt_1Hz = 1'b0;
        total++; if (digits !== 12'h000 || dut.r_state !== ST_IDLE) begin
            $display("FAIL post_reset got %h st=%0d want 000 IDLE", digits, dut.r_state); bad++; end
    endtask

    initial begin
        clrn        = 1'b0;
        loadn       = 1'b1;
        enablen     = 1'b1;
        pgt_1Hz     = 1'b0;
        in_sec_ones = 4'd0;
        in_sec_tens = 4'd0;
        in_min_ones = 4'd0;
        #12;
        test_reset();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        test_load();
        test_count();
        test_expire();
        test_sanitise();
        test_drop();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmss_countdown_timer.md
Name: mmss_countdown_timer

Overview:
Consumer end of the keypad timer-entry path. Parallel-loads the three BCD digits (min_ones, sec_tens, sec_ones) while loadn is low. Once loaded and enabled, it counts the value down once per rising edge of the pgt_1Hz time base and flags expiry at 0:00. It feeds the display mux and the magnetron/door control logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on pgt_1Hz before edge detection (minimum 2)
BLANK_CODE, 4'hF, digit code meaning "no key entered"; loaded as 0
SEC_TENS_RELOAD, 5, value sec_tens takes on borrow

Ports:
clk  in  1  system clock (100 Hz domain)
clrn  in  1  asynchronous active-low reset
loadn  in  1  active-low parallel load, level-sensitive
enablen  in  1  active-low count enable (start pressed, door closed)
pgt_1Hz  in  1  1 Hz time base; asynchronous to clk as far as this block is concerned
in_sec_ones  in  4  BCD digit from entry block
in_sec_tens  in  4  BCD digit from entry block
in_min_ones  in  4  BCD digit from entry block
sec_ones  out  4  current seconds units
sec_tens  out  4  current seconds tens
min_ones  out  4  current minutes units
zero  out  1  high when all three digits are 0
running  out  1  high in RUNNING state
expired  out  1  one-clk pulse on reaching 0:00 by counting

Behaviour:
- Reset (clrn=0, asynchronous): all digits 0, state IDLE, zero=1, running=0, expired=0, synchronizer and edge flops 0.
- Tick: pgt_1Hz passes through SYNC_STAGES flops. A previous-value flop then detects a 0->1 transition. tick is high for exactly one clk per rising edge.
  - Latency from pgt_1Hz rising to a digit update is SYNC_STAGES+1 clk edges.
  - A tick that appears right after reset release is harmless, because the state is IDLE.
- Load sanitising: any input digit above 9, including BLANK_CODE, loads as 0. sec_tens values 6..9 are accepted as-is (e.g. "90" means 90 s).
- States: IDLE, LOAD, PAUSED, RUNNING, DONE.
  - Any state, loadn=0 -> LOAD. Digits are captured every clk while in LOAD. loadn has top priority over tick and enablen.
  - LOAD, loadn=1 -> IDLE if the captured value is 0:00, else PAUSED.
  - PAUSED, enablen=0 -> RUNNING. Digits are held.
  - RUNNING, enablen=1 -> PAUSED. Digits are held.
  - RUNNING, enablen=0, tick=1 -> decrement. If the value was 0:01, the result is 0:00, the next state is DONE and expired=1 for that one clk.
  - A tick arriving in the same clk that enablen goes high is dropped.
  - DONE and IDLE hold 0:00 and ignore enablen and tick. Only loadn leaves them.
- Decrement (BCD, registered, applied at the clk edge where tick is seen):
  - sec_ones: 1..9 decrements by 1; 0 -> 9 with a borrow.
  - sec_tens on borrow: 1..9 decrements by 1; 0 -> SEC_TENS_RELOAD with a borrow.
  - min_ones on borrow: decrements by 1. It is never decremented from 0, because a value of 0:00 is never in RUNNING.
- Outputs: zero is combinational from the digit registers. running and expired are registered.
- Mid-operation reset forces the IDLE/zero outputs immediately. Nothing is retained.
- loadn=0 during RUNNING: the count is aborted and the new digits are loaded. expired is not pulsed.

Decomposition:
- Shared package timer_pkg holds:
  - the state enum (IDLE, LOAD, PAUSED, RUNNING, DONE);
  - BLANK_CODE, DIGIT_MAX=9 and SEC_TENS_RELOAD=5;
  - a BCD-digit typedef, 4 bits.
- One sub-module, bcd_down_digit. Inputs: clk, clrn, load, load_val, dec, wrap_val. Outputs: q, borrow_out, where borrow_out = dec & (q==0).
- The top instantiates three bcd_down_digit instances, plus the synchronizer/edge detector and the FSM.

Test Plan:
- Reset then load 1:30 and release loadn: digits 1,3,0; zero=0; state PAUSED; no counting without enablen.
- From 1:30, enablen=0 and 3 pgt_1Hz edges: 1:29, 1:28, 1:27, each update exactly SYNC_STAGES+1 clk after the edge. Then 28 further edges: 0:59.
- Load 0:02 and run 2 edges: 0:01, then 0:00. expired high for exactly 1 clk, state DONE, running=0. Further edges leave 0:00.
- Load F,F,5 (blank digits): loads 0:05. Load 0:00: IDLE; enablen=0 gives running=0.
- Running at 0:10: enablen=1 in the same clk as tick, so the tick is dropped and the value holds 0:10. Then enablen=0 and the next edge gives 0:09.
- Running at 2:00: assert loadn=0 with digits 0,4,5 in a tick cycle, giving 0:45 and no expired. Assert clrn=0 mid-count: outputs go to 0:00, zero=1 without waiting for a clk edge.
